key_debouncer: RTL



---
 rtl/key_debouncer_if.sv | 25 ++
 rtl/key_debouncer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/key_debouncer_if.sv
// Key event bundle: raw board key in, debounced level and one-cycle event pulses out.
// The debouncer sits on the slave side and the key event consumer on the master side.
interface key_debouncer_if;
  logic key_i;
  logic pressed_o;
  logic press_o;
  logic release_o;
  logic repeat_o;

  modport master (
    output key_i,
    input  pressed_o,
    input  press_o,
    input  release_o,
    input  repeat_o
  );

  modport slave (
    input  key_i,
    output pressed_o,
    output press_o,
    output release_o,
    output repeat_o
  );
endinterface

// File: rtl/key_debouncer.sv
// Active-low push-button debouncer. It produces registered press, release and
// auto-repeat pulses, plus a debounced "pressed" level.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic             clk100_i,
  input  logic             rst_i,
  key_debouncer_if.slave   kif
);

  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_W   = $clog2(RP_MAX);

  localparam logic [DB_W-1:0] DB_TC     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_DLY_TC = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_PER_TC = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            ks;
  logic [DB_W-1:0] db_q, db_d;
  logic [RP_W-1:0] rp_q, rp_d, rp_tc;
  logic            rpf_q, rpf_d;
  logic            pressed_q, pressed_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            rep_q, rep_d;

  // The synchronizer resets to "released" so a key held through reset reads as a new press.
  always_ff @(posedge clk100_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], kif.key_i};
  end

  assign ks    = sync_q[1];
  assign rp_tc = rpf_q ? RP_DLY_TC : RP_PER_TC;

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    rp_d    = rp_q;
    rpf_d   = rpf_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rep_d   = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (!ks) begin
          state_d = PRESS_WAIT;
          db_d    = '0;
        end
      end
      PRESS_WAIT: begin
        if (ks) begin
          state_d = RELEASED;
        end else if (db_q == DB_TC) begin
          state_d = HELD;
          press_d = 1'b1;
          rp_d    = '0;
          rpf_d   = 1'b1;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      HELD: begin
        // A release start wins over a repeat terminal count. rp_cnt stays frozen for a possible bounce back.
        if (ks) begin
          state_d = RELEASE_WAIT;
          db_d    = '0;
        end else if (REPEAT_EN && (rp_q == rp_tc)) begin
          rep_d = 1'b1;
          rp_d  = '0;
          rpf_d = 1'b0;
        end else if (REPEAT_EN) begin
          rp_d = rp_q + RP_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!ks) begin
          state_d = HELD;
        end else if (db_q == DB_TC) begin
          state_d = RELEASED;
          rel_d   = 1'b1;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
    pressed_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      state_q   <= RELEASED;
      db_q      <= '0;
      rp_q      <= '0;
      rpf_q     <= 1'b0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_q      <= db_d;
      rp_q      <= rp_d;
      rpf_q     <= rpf_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      rep_q     <= rep_d;
    end
  end

  assign kif.pressed_o = pressed_q;
  assign kif.press_o   = press_q;
  assign kif.release_o = rel_q;
  assign kif.repeat_o  = rep_q;

endmodule
